// File: rtl/jmb_window_gen.sv
// K x K sliding-window generator for raster-scan pixel streams.
// Tracks frame position, flags interior windows, marks end of frame and resyncs on in_sof.
module jmb_window_gen #(
    parameter int unsigned PixelWidth  = 8,
    parameter int unsigned WinSize     = 3,
    parameter int unsigned ImageWidth  = 512,
    parameter int unsigned ImageHeight = 512,
    localparam int unsigned RowW = $clog2(ImageHeight),
    localparam int unsigned ColW = $clog2(ImageWidth)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_valid,
    input  logic                                  i_sof,
    input  logic [PixelWidth-1:0]                 i_data,
    output logic [WinSize*WinSize*PixelWidth-1:0] o_window,
    output logic                                  o_valid,
    output logic                                  o_eof,
    output logic [RowW-1:0]                       o_row,
    output logic [ColW-1:0]                       o_col,
    output logic                                  o_sync_err
);

    localparam int K     = int'(WinSize);
    localparam int P     = int'(PixelWidth);
    localparam int Depth = int'(ImageWidth) - int'(WinSize);

    localparam logic [ColW-1:0] ColLast  = ColW'(ImageWidth - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(ImageHeight - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(WinSize - 1);
    localparam logic [RowW-1:0] RowFirst = RowW'(WinSize - 1);

    logic [P-1:0]    r_win [K][K];
    logic [P-1:0]    r_lb  [K-1][Depth];
    // Coordinates the next accepted pixel will take unless it carries in_sof.
    logic [RowW-1:0] r_row;
    logic [ColW-1:0] r_col;
    logic [RowW-1:0] r_out_row;
    logic [ColW-1:0] r_out_col;
    logic            r_valid;
    logic            r_eof;
    logic            r_sync_err;

    logic [P-1:0]    w_feed [K];
    logic [RowW-1:0] w_cur_row;
    logic [ColW-1:0] w_cur_col;
    logic [RowW-1:0] w_nxt_row;
    logic [ColW-1:0] w_nxt_col;
    logic            w_sync_err;
    logic            w_in_window;
    logic            w_last;

    always_comb begin
        w_cur_row  = r_row;
        w_cur_col  = r_col;
        w_sync_err = 1'b0;
        if (i_sof) begin
            w_cur_row  = '0;
            w_cur_col  = '0;
            w_sync_err = (r_row != '0) || (r_col != '0);
        end

        w_nxt_row = w_cur_row;
        w_nxt_col = w_cur_col + ColW'(1);
        if (w_cur_col == ColLast) begin
            w_nxt_col = '0;
            w_nxt_row = (w_cur_row == RowLast) ? '0 : w_cur_row + RowW'(1);
        end

        w_in_window = (w_cur_row >= RowFirst) && (w_cur_col >= ColFirst);
        w_last      = (w_cur_row == RowLast) && (w_cur_col == ColLast);
    end

    // Top rows refill from the line buffers; the newest row takes the input pixel.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            w_feed[r] = r_lb[r][Depth-1];
        end
        w_feed[K-1] = i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            for (int r = 0; r < K - 1; r++) begin
                for (int d = 0; d < Depth; d++) begin
                    r_lb[r][d] <= '0;
                end
            end
            r_row      <= '0;
            r_col      <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_valid    <= 1'b0;
            r_eof      <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_eof      <= 1'b0;
            r_sync_err <= 1'b0;
            if (i_valid) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                    r_win[r][K-1] <= w_feed[r];
                end
                // The pixel leaving column 0 of row r+1 waits one line minus K for row r.
                for (int r = 0; r < K - 1; r++) begin
                    r_lb[r][0] <= r_win[r+1][0];
                    for (int d = 1; d < Depth; d++) begin
                        r_lb[r][d] <= r_lb[r][d-1];
                    end
                end
                r_row      <= w_nxt_row;
                r_col      <= w_nxt_col;
                r_out_row  <= w_cur_row;
                r_out_col  <= w_cur_col;
                r_valid    <= w_in_window;
                r_eof      <= w_in_window && w_last;
                r_sync_err <= w_sync_err;
            end
        end
    end

    for (genvar r = 0; r < K; r++) begin : g_win_row
        for (genvar c = 0; c < K; c++) begin : g_win_col
            assign o_window[((r*K)+c)*P +: P] = r_win[r][c];
        end
    end

    assign o_valid    = r_valid;
    assign o_eof      = r_eof;
    assign o_row      = r_out_row;
    assign o_col      = r_out_col;
    assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_jmb_window_gen.sv
// Randomised bench for jmb_window_gen: K=3, W=8, H=6 against a frame-image reference model.
module tb_jmb_window_gen;

    localparam int K    = 3;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int P    = 8;
    localparam int RowW = $clog2(H);
    localparam int ColW = $clog2(W);

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_valid;
    logic              i_sof;
    logic [P-1:0]      i_data;
    logic [K*K*P-1:0]  o_window;
    logic              o_valid;
    logic              o_eof;
    logic [RowW-1:0]   o_row;
    logic [ColW-1:0]   o_col;
    logic              o_sync_err;

    always #5 clk = ~clk;

    jmb_window_gen #(
        .PixelWidth (P),
        .WinSize    (K),
        .ImageWidth (W),
        .ImageHeight(H)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_sof     (i_sof),
        .i_data    (i_data),
        .o_window  (o_window),
        .o_valid   (o_valid),
        .o_eof     (o_eof),
        .o_row     (o_row),
        .o_col     (o_col),
        .o_sync_err(o_sync_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the current frame as an image plus the coordinate walk.
    logic [P-1:0] img [H][W];
    int m_row = 0, m_col = 0;
    int e_row = 0, e_col = 0;

    // Per-segment observations.
    int               acc_cnt, first_valid_acc, n_valid_obs, n_eof_obs, n_sync_obs;
    logic [K*K*P-1:0] first_win, eof_win;
    int               eof_row, eof_col;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        acc_cnt         = 0;
        first_valid_acc = 0;
        n_valid_obs     = 0;
        n_eof_obs       = 0;
        n_sync_obs      = 0;
        first_win       = '0;
        eof_win         = '0;
        eof_row         = -1;
        eof_col         = -1;
    endtask

    task automatic step(input logic rst, input logic vld, input logic sof, input logic [P-1:0] d);
        logic             ev, eeof, esync;
        logic [K*K*P-1:0] exp_win;
        i_rst   = rst;
        i_valid = vld;
        i_sof   = sof;
        i_data  = d;
        @(posedge clk);
        #1;
        ev    = 1'b0;
        eeof  = 1'b0;
        esync = 1'b0;
        if (rst) begin
            m_row = 0;
            m_col = 0;
            e_row = 0;
            e_col = 0;
            check_eq("rst_window", 128'(o_window), 128'(0));
        end else if (vld) begin
            if (sof) begin
                esync = (m_row != 0) || (m_col != 0);
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = d;
            e_row = m_row;
            e_col = m_col;
            ev    = (m_row >= K - 1) && (m_col >= K - 1);
            eeof  = ev && (m_row == H - 1) && (m_col == W - 1);
            acc_cnt++;
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end

        check_eq("valid", 128'(o_valid), 128'(ev));
        check_eq("eof", 128'(o_eof), 128'(eeof));
        check_eq("sync_err", 128'(o_sync_err), 128'(esync));
        check_eq("row", 128'(o_row), 128'(e_row));
        check_eq("col", 128'(o_col), 128'(e_col));
        if (ev) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    exp_win[((r*K)+c)*P +: P] = img[e_row-K+1+r][e_col-K+1+c];
                end
            end
            check_eq("window", 128'(o_window), 128'(exp_win));
        end

        if (!rst) begin
            if (o_valid && n_valid_obs == 0) begin
                first_valid_acc = acc_cnt;
                first_win       = o_window;
            end
            if (o_valid) n_valid_obs++;
            if (o_valid && o_eof) begin
                n_eof_obs++;
                eof_win = o_window;
                eof_row = int'(o_row);
                eof_col = int'(o_col);
            end
            if (o_sync_err) n_sync_obs++;
        end
    endtask

    // Sends npix pixels of a frame starting at (0,0); pixel data = offset + 8*row + col.
    task automatic send_frame(input bit sof_first, input int npix, input int gap, input int offset);
        for (int i = 0; i < npix; i++) begin
            for (int g = 0; g < 6 && $urandom_range(99) < gap; g++) begin
                step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
            end
            step(1'b0, 1'b1, sof_first && (i == 0), 8'(offset + i));
        end
    endtask

    initial begin
        logic [K*K*P-1:0] first_exp;
        logic [K*K*P-1:0] last_exp;
        first_exp = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        last_exp  = {8'd47, 8'd46, 8'd45, 8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29};

        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                img[r][c] = '0;
            end
        end
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_sof   = 1'b0;
        i_data  = 8'hFF;
        mark();

        // Reset held with valid input.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'hFF);

        // Frame 1: continuous.
        mark();
        send_frame(1'b1, W * H, 0, 0);
        check_eq("f1_nvalid", 128'(n_valid_obs), 128'(24));
        check_eq("f1_first_at", 128'(first_valid_acc), 128'(19));
        check_eq("f1_first_win", 128'(first_win), 128'(first_exp));
        check_eq("f1_neof", 128'(n_eof_obs), 128'(1));
        check_eq("f1_eof_win", 128'(eof_win), 128'(last_exp));
        check_eq("f1_eof_row", 128'(eof_row), 128'(5));
        check_eq("f1_eof_col", 128'(eof_col), 128'(7));

        // Frame 2: back-to-back, ~40% idle gaps.
        mark();
        send_frame(1'b1, W * H, 40, 0);
        check_eq("f2_nvalid", 128'(n_valid_obs), 128'(24));
        check_eq("f2_neof", 128'(n_eof_obs), 128'(1));
        check_eq("f2_eof_win", 128'(eof_win), 128'(last_exp));
        check_eq("f2_nsync", 128'(n_sync_obs), 128'(0));

        // Frame 3: in_sof arrives where (3,4) was due.
        send_frame(1'b1, 3 * W + 4, 0, 0);
        mark();
        send_frame(1'b1, W * H, 20, 0);
        check_eq("f3_nsync", 128'(n_sync_obs), 128'(1));
        check_eq("f3_first_at", 128'(first_valid_acc), 128'(19));
        check_eq("f3_first_win", 128'(first_win), 128'(first_exp));
        check_eq("f3_nvalid", 128'(n_valid_obs), 128'(24));

        // Frame 4: reset where (4,5) was due, restart without in_sof.
        send_frame(1'b1, 4 * W + 5, 0, 0);
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        mark();
        send_frame(1'b0, W * H, 30, 100);
        check_eq("f4_first_at", 128'(first_valid_acc), 128'(19));
        check_eq("f4_first_win", 128'(first_win),
                 128'({8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100}));
        check_eq("f4_nvalid", 128'(n_valid_obs), 128'(24));
        check_eq("f4_neof", 128'(n_eof_obs), 128'(1));
        check_eq("f4_nsync", 128'(n_sync_obs), 128'(0));

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
